// File: rtl/mux_sweep_checker.sv
// Self-checking sweep stage around the 2:1 select gate z = c ? b : a.
// Walks all eight {a,b,c} vectors, samples z after a settle window and tallies results.
module mux_sweep_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       z,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_cnt,
    output logic [3:0] fail_cnt,
    output logic [2:0] first_fail,
    output logic       first_fail_valid,
    output logic       all_pass
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       expected;
    logic       hit;

    // The vector index register is the gate drive, so a/b/c are registered.
    assign {a, b, c} = idx;
    assign expected  = c ? b : a;
    // Case equality so an unknown z is scored as a failure in simulation.
    assign hit       = (z === expected);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_SETTLE;
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nx = S_CHECK;
            end
            S_CHECK:  begin
                busy     = 1'b1;
                state_nx = (idx == 3'd7) ? S_DONE : S_SETTLE;
            end
            S_DONE:   begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx              <= 3'd0;
            cnt              <= 4'd0;
            pass_cnt         <= 4'd0;
            fail_cnt         <= 4'd0;
            first_fail       <= 3'd0;
            first_fail_valid <= 1'b0;
            all_pass         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx              <= 3'd0;
                    cnt              <= CNT_INIT;
                    pass_cnt         <= 4'd0;
                    fail_cnt         <= 4'd0;
                    first_fail       <= 3'd0;
                    first_fail_valid <= 1'b0;
                    all_pass         <= 1'b0;
                end
                S_SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                S_CHECK: begin
                    if (hit) begin
                        pass_cnt <= pass_cnt + 4'd1;
                    end else begin
                        fail_cnt <= fail_cnt + 4'd1;
                        if (!first_fail_valid) begin
                            first_fail       <= idx;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // Last vector stays on the gate inputs after the run.
                    if (idx != 3'd7) begin
                        idx <= idx + 3'd1;
                        cnt <= CNT_INIT;
                    end
                end
                S_DONE: all_pass <= (fail_cnt == 4'd0);
                default: ;
            endcase
        end
    end

endmodule
